// File: rtl/exec_ctrl_if.sv
// Instruction handshake and decoded-control bundle between fetch, exec_ctrl and the datapath.
// The master modport is the fetch/datapath side; exec_ctrl connects through the slave modport.
interface exec_ctrl_if #(
  parameter int unsigned IW  = 16,
  parameter int unsigned RAW = 4
);
  logic           instr_valid;
  logic           instr_ready;
  logic [IW-1:0]  instr;
  logic [RAW-1:0] choose_reg;
  logic [2:0]     S;
  logic [1:0]     res_dest;
  logic           exec_en;
  logic           wb_en;
  logic           illegal;
  logic           busy;

  modport master (
    output instr_valid, instr,
    input  instr_ready, choose_reg, S, res_dest, exec_en, wb_en, illegal, busy
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, choose_reg, S, res_dest, exec_en, wb_en, illegal, busy
  );
endinterface

// File: rtl/exec_ctrl.sv
// Execute-stage control: decodes one instruction per handshake and sequences DECODE/EXEC/WB.
// Define STEP_MODE_EN to hold EXEC until a synchronised rising edge on manual_plus.
module exec_ctrl #(
  parameter int unsigned IW          = 16,
  parameter int unsigned RAW         = 4,
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             manual_plus,
  exec_ctrl_if.slave       bus,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned CntW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(EXEC_CYCLES - 1);

  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpAlu = 4'b0111;
  localparam logic [3:0] OpBlk = 4'b1000;
  localparam logic [3:0] OpNop = 4'b1111;

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    instr_q, instr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       s_q, s_d;
  logic [RAW-1:0]   choose_q, choose_d;
  logic [1:0]       dest_q, dest_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             step_ok;

  logic [3:0]     opcode;
  logic [RAW-1:0] r_field;
  logic [1:0]     dest_a;
  logic [1:0]     dest_b;

  assign opcode  = instr_q[IW-1 -: 4];
  assign r_field = instr_q[IW-5 -: RAW];
  assign dest_a  = instr_q[IW-5-RAW -: 2];
  assign dest_b  = instr_q[IW-7 -: 2];

  // Operand bits below the decoded fields are carried but never interpreted.
  logic unused_instr;
  assign unused_instr = ^instr_q;

`ifdef STEP_MODE_EN
  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= manual_plus;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Only consulted once the counter has saturated, so early edges are simply lost.
  assign step_ok = sync2_q & ~prev_q;
`else
  logic unused_manual_plus;
  assign unused_manual_plus = manual_plus;
  assign step_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    choose_d  = choose_q;
    dest_d    = dest_q;
    illegal_d = 1'b0;
    count_d   = count_q;

    unique case (state_q)
      StIdle: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = StIdle;
        cnt_d   = '0;
        case (opcode)
          OpAdd: begin
            s_d      = 3'b001;
            choose_d = r_field;
            dest_d   = dest_a;
            state_d  = StExec;
          end
          OpAlu: begin
            s_d      = 3'b011;
            choose_d = r_field;
            dest_d   = dest_a;
            state_d  = StExec;
          end
          OpBlk: begin
            s_d                 = 3'b110;
            choose_d            = '0;
            choose_d[RAW-1 -: 2] = r_field[RAW-1 -: 2];
            dest_d              = dest_b;
            state_d             = StExec;
          end
          OpNop:   count_d = count_q + CNT_W'(1);
          default: illegal_d = 1'b1;
        endcase
      end
      StExec: begin
        // Counter saturates on its last value so step mode can hold EXEC indefinitely.
        if (cnt_q != LastCnt) begin
          cnt_d = cnt_q + CntW'(1);
        end else if (step_ok) begin
          state_d = StWb;
        end
      end
      StWb: begin
        count_d = count_q + CNT_W'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      cnt_q     <= '0;
      s_q       <= '0;
      choose_q  <= '0;
      dest_q    <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      choose_q  <= choose_d;
      dest_q    <= dest_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign bus.instr_ready = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.exec_en     = (state_q == StExec);
  assign bus.wb_en       = (state_q == StWb);
  assign bus.illegal     = illegal_q;
  assign bus.S           = s_q;
  assign bus.choose_reg  = choose_q;
  assign bus.res_dest    = dest_q;
  assign instr_count     = count_q;

endmodule
